// File: rtl/fifo_credit_return_if.sv
// Link/arbiter-side signals of the credit-returning input buffer.
// master drives the flits and the grants; slave is the buffer itself.
interface fifo_credit_return_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic                  valid_in;
  logic [DATA_WIDTH-1:0] rx;
  logic                  read_en_N;
  logic                  read_en_E;
  logic                  read_en_W;
  logic                  read_en_S;
  logic                  read_en_L;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  empty;
  logic                  full;
  logic [CW-1:0]         count;
  logic                  credit_out;
  logic                  overflow_err;
  logic                  underflow_err;

  modport master (
    output valid_in, rx, read_en_N, read_en_E, read_en_W, read_en_S, read_en_L,
    input  data_out, empty, full, count, credit_out, overflow_err, underflow_err
  );

  modport slave (
    input  valid_in, rx, read_en_N, read_en_E, read_en_W, read_en_S, read_en_L,
    output data_out, empty, full, count, credit_out, overflow_err, underflow_err
  );
endinterface

// File: rtl/fifo_credit_return.sv
// Router input-port flit buffer: stores upstream flits, pops on any output grant,
// and returns one registered credit pulse per popped flit.
module fifo_credit_return #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  fifo_credit_return_if.slave  bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count_q;
  logic                  credit_q;
  logic                  overflow_q;
  logic                  underflow_q;

  logic empty_c;
  logic full_c;
  logic rd_req;
  logic rd_ok;
  logic wr_ok;

  // Occupancy decode and pop/push qualification
  assign empty_c = (count_q == '0);
  assign full_c  = (count_q == CW'(DEPTH));
  assign rd_req  = bus.read_en_N | bus.read_en_E | bus.read_en_W |
                   bus.read_en_S | bus.read_en_L;
  assign rd_ok   = rd_req & ~empty_c;
  // A pop in the same cycle frees the slot, so a write at full is still accepted
  assign wr_ok   = bus.valid_in & (~full_c | rd_ok);

  // Flit storage carries no reset; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= bus.rx;
    end
  end

  // Pointers, occupancy, credit return and sticky error flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count_q     <= '0;
      credit_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      credit_q <= rd_ok;
      if (bus.valid_in && full_c && !rd_ok) begin
        overflow_q <= 1'b1;
      end
      if (rd_req && empty_c) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign bus.data_out      = mem[rd_ptr];
  assign bus.empty         = empty_c;
  assign bus.full          = full_c;
  assign bus.count         = count_q;
  assign bus.credit_out    = credit_q;
  assign bus.overflow_err  = overflow_q;
  assign bus.underflow_err = underflow_q;
endmodule

// File: tb/tb_fifo_credit_return.sv
// Directed bench for fifo_credit_return: fill/drain, full bypass, overflow,
// underflow, pointer wrap and mid-operation reset.
module tb_fifo_credit_return;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned DEPTH      = 4;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  int   credits;
  int   exp_next;

  fifo_credit_return_if #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) bus ();

  fifo_credit_return #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.valid_in  = 1'b0;
    bus.rx        = '0;
    bus.read_en_N = 1'b0;
    bus.read_en_E = 1'b0;
    bus.read_en_W = 1'b0;
    bus.read_en_S = 1'b0;
    bus.read_en_L = 1'b0;
  endtask

  task automatic write_flit(input logic [31:0] d);
    bus.valid_in = 1'b1;
    bus.rx       = d;
    tick();
    bus.valid_in = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_credit", 32'(bus.credit_out), 32'd0);
    check("rst_ovf", 32'(bus.overflow_err), 32'd0);
    check("rst_unf", 32'(bus.underflow_err), 32'd0);
    reset = 1'b1;
    tick();

    // 1: fill
    write_flit(32'hA1);
    check("t1_vis_data", bus.data_out, 32'hA1);
    check("t1_vis_empty", 32'(bus.empty), 32'd0);
    write_flit(32'hA2);
    write_flit(32'hA3);
    write_flit(32'hA4);
    check("t1_full", 32'(bus.full), 32'd1);
    check("t1_count", 32'(bus.count), 32'd4);
    check("t1_data", bus.data_out, 32'hA1);
    check("t1_credit", 32'(bus.credit_out), 32'd0);

    // 2: drain on East grant
    bus.read_en_E = 1'b1;
    tick();
    check("t2_d1", bus.data_out, 32'hA2);
    check("t2_c1", 32'(bus.credit_out), 32'd1);
    check("t2_cnt1", 32'(bus.count), 32'd3);
    tick();
    check("t2_d2", bus.data_out, 32'hA3);
    check("t2_c2", 32'(bus.credit_out), 32'd1);
    tick();
    check("t2_d3", bus.data_out, 32'hA4);
    check("t2_c3", 32'(bus.credit_out), 32'd1);
    tick();
    check("t2_empty", 32'(bus.empty), 32'd1);
    check("t2_c4", 32'(bus.credit_out), 32'd1);
    check("t2_unf_clear", 32'(bus.underflow_err), 32'd0);
    bus.read_en_E = 1'b0;
    tick();
    check("t2_c_end", 32'(bus.credit_out), 32'd0);

    // 3: write + read at full
    write_flit(32'hA1);
    write_flit(32'hA2);
    write_flit(32'hA3);
    write_flit(32'hA4);
    bus.valid_in  = 1'b1;
    bus.rx        = 32'hB5;
    bus.read_en_N = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    check("t3_count", 32'(bus.count), 32'd4);
    check("t3_data", bus.data_out, 32'hA2);
    check("t3_credit", 32'(bus.credit_out), 32'd1);
    check("t3_ovf", 32'(bus.overflow_err), 32'd0);
    tick();
    check("t3_d_a3", bus.data_out, 32'hA3);
    tick();
    check("t3_d_a4", bus.data_out, 32'hA4);
    tick();
    check("t3_d_b5", bus.data_out, 32'hB5);
    tick();
    check("t3_empty", 32'(bus.empty), 32'd1);
    bus.read_en_N = 1'b0;
    tick();

    // 4: overflow drop
    write_flit(32'h11);
    write_flit(32'h12);
    write_flit(32'h13);
    write_flit(32'h14);
    write_flit(32'hC6);
    check("t4_count", 32'(bus.count), 32'd4);
    check("t4_ovf", 32'(bus.overflow_err), 32'd1);
    check("t4_data", bus.data_out, 32'h11);
    check("t4_credit", 32'(bus.credit_out), 32'd0);
    tick();
    check("t4_ovf_sticky", 32'(bus.overflow_err), 32'd1);
    bus.read_en_W = 1'b1;
    tick();
    tick();
    tick();
    check("t4_tail", bus.data_out, 32'h14);
    tick();
    check("t4_empty", 32'(bus.empty), 32'd1);
    bus.read_en_W = 1'b0;
    tick();
    check("t4_ovf_after", 32'(bus.overflow_err), 32'd1);

    // 5: underflow
    bus.read_en_L = 1'b1;
    tick();
    bus.read_en_L = 1'b0;
    check("t5_count", 32'(bus.count), 32'd0);
    check("t5_credit", 32'(bus.credit_out), 32'd0);
    check("t5_unf", 32'(bus.underflow_err), 32'd1);
    tick();
    check("t5_unf_sticky", 32'(bus.underflow_err), 32'd1);
    check("t5_credit2", 32'(bus.credit_out), 32'd0);

    // 5b: write + read at empty stores the flit, no credit
    bus.valid_in  = 1'b1;
    bus.rx        = 32'h77;
    bus.read_en_S = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    check("t5b_count", 32'(bus.count), 32'd1);
    check("t5b_data", bus.data_out, 32'h77);
    check("t5b_credit", 32'(bus.credit_out), 32'd0);
    tick();
    bus.read_en_S = 1'b0;
    check("t5b_pop_empty", 32'(bus.empty), 32'd1);
    check("t5b_pop_credit", 32'(bus.credit_out), 32'd1);
    tick();

    // 6: ordering across pointer wrap, occupancy 1..3
    credits  = 0;
    exp_next = 0;
    for (int i = 0; i < 3; i++) begin
      bus.valid_in = 1'b1;
      bus.rx       = 32'(i);
      tick();
      credits += int'(bus.credit_out);
    end
    check("t6_occ3", 32'(bus.count), 32'd3);
    bus.read_en_W = 1'b1;
    for (int i = 3; i < 10; i++) begin
      bus.rx = 32'(i);
      check("t6_order", bus.data_out, 32'(exp_next));
      tick();
      exp_next++;
      credits += int'(bus.credit_out);
    end
    bus.valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t6_order_tail", bus.data_out, 32'(exp_next));
      tick();
      exp_next++;
      credits += int'(bus.credit_out);
    end
    bus.read_en_W = 1'b0;
    tick();
    credits += int'(bus.credit_out);
    check("t6_credits", 32'(credits), 32'd10);
    check("t6_empty", 32'(bus.empty), 32'd1);

    // 7: reset with 2 flits stored and a credit pulse in flight
    write_flit(32'hE1);
    write_flit(32'hE2);
    write_flit(32'hE3);
    bus.read_en_N = 1'b1;
    tick();
    check("t7_pre_count", 32'(bus.count), 32'd2);
    check("t7_pre_credit", 32'(bus.credit_out), 32'd1);
    reset = 1'b0;
    #1;
    check("t7_empty", 32'(bus.empty), 32'd1);
    check("t7_count", 32'(bus.count), 32'd0);
    check("t7_credit", 32'(bus.credit_out), 32'd0);
    check("t7_ovf", 32'(bus.overflow_err), 32'd0);
    check("t7_unf", 32'(bus.underflow_err), 32'd0);
    bus.read_en_N = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("t7_post_empty", 32'(bus.empty), 32'd1);
    write_flit(32'h5A);
    check("t7_post_data", bus.data_out, 32'h5A);
    check("t7_post_count", 32'(bus.count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
